// File: rtl/digest_hex_tx.sv
// rtl/digest_hex_tx.sv - streams a latched digest to a UART TX core as ASCII hex, MS nibble first
// Optional feature macro: DIGEST_HEX_CRLF_EN (append 8'h0D, 8'h0A after the hex characters)
module digest_hex_tx #(
  parameter int DIGEST_BITS = 256,
  parameter bit UPPERCASE   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   digest_valid,
  input  logic [DIGEST_BITS-1:0] digest,
  output logic                   digest_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic                   busy,
  output logic                   done
);

  localparam int HEX_CHARS = DIGEST_BITS / 4;
`ifdef DIGEST_HEX_CRLF_EN
  localparam int TOTAL_CHARS = HEX_CHARS + 2;
`else
  localparam int TOTAL_CHARS = HEX_CHARS;
`endif
  localparam int CW = $clog2(TOTAL_CHARS + 1);
  localparam logic [CW-1:0] LAST_IDX   = CW'(TOTAL_CHARS - 1);
  localparam logic [7:0]    ALPHA_BASE = UPPERCASE ? 8'h41 : 8'h61;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t                 state, state_d;
  logic [DIGEST_BITS-1:0] shift_reg, shift_reg_d;
  logic [CW-1:0]          cnt, cnt_d;
  logic                   digest_ready_d, tx_start_d, busy_d, done_d;
  logic [7:0]             tx_data_d;
  logic [3:0]             nib;
  logic [7:0]             cur_char;

  assign nib = shift_reg[DIGEST_BITS-1 -: 4];

  // Character for the current position: hex digit of the top nibble, or the line terminator
  always_comb begin
    if (nib < 4'd10) begin
      cur_char = 8'h30 + {4'h0, nib};
    end else begin
      cur_char = ALPHA_BASE + {4'h0, nib} - 8'd10;
    end
`ifdef DIGEST_HEX_CRLF_EN
    if (cnt == CW'(HEX_CHARS)) begin
      cur_char = 8'h0D;
    end else if (cnt > CW'(HEX_CHARS)) begin
      cur_char = 8'h0A;
    end
`endif
  end

  // Registered state and outputs; asynchronous reset aborts any message in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      shift_reg    <= '0;
      cnt          <= '0;
      digest_ready <= 1'b1;
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      shift_reg    <= shift_reg_d;
      cnt          <= cnt_d;
      digest_ready <= digest_ready_d;
      tx_start     <= tx_start_d;
      tx_data      <= tx_data_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

  // Next-state logic: one strobe per character, gated on seeing tx_busy rise and fall
  always_comb begin
    state_d        = state;
    shift_reg_d    = shift_reg;
    cnt_d          = cnt;
    digest_ready_d = digest_ready;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data;
    busy_d         = busy;
    done_d         = 1'b0;
    case (state)
      IDLE: begin
        if (digest_valid && digest_ready) begin
          shift_reg_d    = digest;
          cnt_d          = '0;
          busy_d         = 1'b1;
          digest_ready_d = 1'b0;
          state_d        = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = cur_char;
          state_d    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (cnt == LAST_IDX) begin
            done_d         = 1'b1;
            busy_d         = 1'b0;
            digest_ready_d = 1'b1;
            state_d        = IDLE;
          end else begin
            shift_reg_d = {shift_reg[DIGEST_BITS-5:0], 4'h0};
            cnt_d       = cnt + 1'b1;
            state_d     = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
